// File: rtl/sccb_slave.sv
// -----------------------------------------------------------------------------
// sccb_slave
//
// Purpose
//   Camera-side SCCB responder with a 256x8 register file.  Used to exercise
//   an SCCB master in simulation and as a camera stand-in on the board.
//   SIOC/SIOD are oversampled on the system clock.  The system clock must run
//   at least 8x faster than SIOC.  The block decodes start and stop conditions
//   and supports:
//     - 3-phase write : ID(0x42) + sub-address + data   -> reg[addr] := data
//     - 2-phase write : ID(0x42) + sub-address          -> read pointer := addr
//     - 2-phase read  : ID(0x43) + data                 -> returns reg[pointer]
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sio_c      in   SCCB clock from the master
//   sio_d_in   in   SCCB data line as seen on the pad
//   sio_d_oe   out  1 = pull SIOD low (open drain, never driven high)
//   wr_strobe  out  1-clk pulse when a register write commits
//   wr_addr    out  address of the committed write (valid with wr_strobe)
//   wr_data    out  data of the committed write (valid with wr_strobe)
//   rd_strobe  out  1-clk pulse when a read byte is loaded for shifting out
//   busy       out  1 from a start condition until the following stop
//
// Handshake note
//   The bus has no valid/ready pairs.  Bus events are the edges of the
//   synchronised pins.  Input bits are taken on SIOC rising edges.  The
//   slave only changes sio_d_oe on SIOC falling edges, so SIOD never moves
//   under the slave's control while SIOC is high.
// -----------------------------------------------------------------------------
module sccb_slave #(
    parameter logic [6:0] DEVICE_ID = 7'h21,
    parameter bit         ACK_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sio_c,
    input  logic       sio_d_in,
    output logic       sio_d_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    output logic       busy
);

    localparam logic [7:0] WR_ID = {DEVICE_ID, 1'b0};
    localparam logic [7:0] RD_ID = {DEVICE_ID, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_ADDR      = 4'd3,
        ST_ADDR_ACK  = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RD_NA     = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection.
    // The flops reset to 1 because both lines idle high on the bus.
    // ------------------------------------------------------------------
    logic c_s1, c_s2, c_q;
    logic d_s1, d_s2, d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            c_q  <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
            d_q  <= 1'b1;
        end else begin
            c_s1 <= sio_c;
            c_s2 <= c_s1;
            c_q  <= c_s2;
            d_s1 <= sio_d_in;
            d_s2 <= d_s1;
            d_q  <= d_s2;
        end
    end

    logic c_rise, c_fall, d_rise, d_fall;
    logic start_evt, stop_evt;

    assign c_rise = c_s2 & ~c_q;
    assign c_fall = ~c_s2 & c_q;
    assign d_rise = d_s2 & ~d_q;
    assign d_fall = ~d_s2 & d_q;

    // SIOC must have been high on both samples, so that a data edge
    // coinciding with a clock edge is not mistaken for start/stop.
    assign start_evt = d_fall & c_s2 & c_q;
    assign stop_evt  = d_rise & c_s2 & c_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [3:0] cnt,      cnt_nxt;       // bits seen in the current phase
    logic [6:0] in_shift, in_shift_nxt;  // first 7 bits of the incoming byte
    logic [6:0] rd_shift, rd_shift_nxt;  // remaining bits of the outgoing byte
    logic [7:0] ptr,      ptr_nxt;       // register pointer
    logic       is_read,  is_read_nxt;   // ID byte was the read ID
    logic       oe_r,     oe_nxt;
    logic       busy_r,   busy_nxt;
    logic       wr_strobe_r, wr_strobe_nxt;
    logic       rd_strobe_r, rd_strobe_nxt;
    logic [7:0] wr_addr_r, wr_addr_nxt;
    logic [7:0] wr_data_r, wr_data_nxt;
    logic       mem_we;

    logic [7:0] mem [0:255];
    logic [7:0] byte_in;
    logic [7:0] rd_byte;

    // The byte being completed on the current rising edge.
    assign byte_in = {in_shift, d_s2};
    assign rd_byte = mem[ptr];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic.
    // Start and stop override every state, so a repeated start is legal
    // anywhere and an aborted byte simply vanishes.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (start_evt) begin
            state_nxt = ST_ID;
        end else if (stop_evt) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_ID: begin
                    if (c_rise && cnt == 4'd7) begin
                        if (byte_in == WR_ID || byte_in == RD_ID) begin
                            state_nxt = ST_ID_ACK;
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_ID_ACK: begin
                    if (c_fall && cnt == 4'd9) begin
                        state_nxt = is_read ? ST_RDATA : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (c_rise && cnt == 4'd7) state_nxt = ST_ADDR_ACK;
                end
                ST_ADDR_ACK: begin
                    if (c_fall && cnt == 4'd9) state_nxt = ST_WDATA;
                end
                ST_WDATA: begin
                    if (c_rise && cnt == 4'd7) state_nxt = ST_WDATA_ACK;
                end
                ST_WDATA_ACK: begin
                    // Extra bytes are discarded.
                    if (c_fall && cnt == 4'd9) state_nxt = ST_IGNORE;
                end
                ST_RDATA: begin
                    if (c_fall && cnt == 4'd7) state_nxt = ST_RD_NA;
                end
                ST_RD_NA: begin
                    // The master's NA bit carries no information.
                    if (c_rise) state_nxt = ST_IGNORE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values.
    // In the ACK states, cnt runs 8 -> 9 to separate the falling edge that
    // starts the acknowledge slot from the one that ends it.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_nxt       = cnt;
        in_shift_nxt  = in_shift;
        rd_shift_nxt  = rd_shift;
        ptr_nxt       = ptr;
        is_read_nxt   = is_read;
        oe_nxt        = oe_r;
        busy_nxt      = busy_r;
        wr_strobe_nxt = 1'b0;
        rd_strobe_nxt = 1'b0;
        wr_addr_nxt   = wr_addr_r;
        wr_data_nxt   = wr_data_r;
        mem_we        = 1'b0;

        if (start_evt) begin
            busy_nxt = 1'b1;
            cnt_nxt  = 4'd0;
            oe_nxt   = 1'b0;
        end else if (stop_evt) begin
            busy_nxt = 1'b0;
            cnt_nxt  = 4'd0;
            oe_nxt   = 1'b0;
        end else begin
            unique case (state)
                ST_ID, ST_ADDR, ST_WDATA: begin
                    if (c_rise) begin
                        in_shift_nxt = byte_in[6:0];
                        cnt_nxt      = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (state == ST_ID) begin
                                is_read_nxt = d_s2;
                            end
                            if (state == ST_ADDR) begin
                                ptr_nxt = byte_in;
                            end
                            if (state == ST_WDATA) begin
                                mem_we        = 1'b1;
                                wr_strobe_nxt = 1'b1;
                                wr_addr_nxt   = ptr;
                                wr_data_nxt   = byte_in;
                            end
                        end
                    end
                end
                ST_ID_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
                    if (c_fall && cnt == 4'd8) begin
                        oe_nxt = ACK_EN;
                    end else if (c_rise && cnt == 4'd8) begin
                        cnt_nxt = 4'd9;
                    end else if (c_fall && cnt == 4'd9) begin
                        cnt_nxt = 4'd0;
                        oe_nxt  = 1'b0;
                        // The acknowledge slot ends on the falling edge where
                        // read bit 7 must appear.
                        if (state == ST_ID_ACK && is_read) begin
                            rd_shift_nxt  = rd_byte[6:0];
                            rd_strobe_nxt = 1'b1;
                            oe_nxt        = ~rd_byte[7];
                        end
                    end
                end
                ST_RDATA: begin
                    if (c_fall) begin
                        if (cnt == 4'd7) begin
                            // Bit 0 has been sampled; release for the NA bit.
                            oe_nxt  = 1'b0;
                            cnt_nxt = 4'd0;
                        end else begin
                            oe_nxt       = ~rd_shift[6];
                            rd_shift_nxt = {rd_shift[5:0], 1'b0};
                            cnt_nxt      = cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    // IDLE, RD_NA and IGNORE never pull the line.
                    oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            in_shift    <= 7'd0;
            rd_shift    <= 7'd0;
            ptr         <= 8'd0;
            is_read     <= 1'b0;
            oe_r        <= 1'b0;
            busy_r      <= 1'b0;
            wr_strobe_r <= 1'b0;
            rd_strobe_r <= 1'b0;
            wr_addr_r   <= 8'd0;
            wr_data_r   <= 8'd0;
        end else begin
            cnt         <= cnt_nxt;
            in_shift    <= in_shift_nxt;
            rd_shift    <= rd_shift_nxt;
            ptr         <= ptr_nxt;
            is_read     <= is_read_nxt;
            oe_r        <= oe_nxt;
            busy_r      <= busy_nxt;
            wr_strobe_r <= wr_strobe_nxt;
            rd_strobe_r <= rd_strobe_nxt;
            wr_addr_r   <= wr_addr_nxt;
            wr_data_r   <= wr_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Register file.  It is cleared on reset so that a reset camera model
    // reads back zero everywhere.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (mem_we) begin
            mem[ptr] <= byte_in;
        end
    end

    assign sio_d_oe  = oe_r;
    assign busy      = busy_r;
    assign wr_strobe = wr_strobe_r;
    assign rd_strobe = rd_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;

endmodule

// File: tb/tb_sccb_slave.sv
// -----------------------------------------------------------------------------
// tb_sccb_slave
//
// Directed bench for sccb_slave.  A behavioural SCCB master drives SIOC and
// an open-drain SIOD.  The wired line is master_d AND NOT sio_d_oe.  Each
// SIOC half period is 8 system clocks.  Expected values are hand-computed
// from the transactions sent.
// -----------------------------------------------------------------------------
module tb_sccb_slave;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sio_c = 1'b1;
    logic       m_d   = 1'b1;
    logic       sio_d_in;
    logic       sio_d_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic       busy;

    assign sio_d_in = m_d & ~sio_d_oe;

    sccb_slave dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sio_c     (sio_c),
        .sio_d_in  (sio_d_in),
        .sio_d_oe  (sio_d_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- event monitors ----------------
    int         wr_cnt  = 0;
    int         rd_cnt  = 0;
    int         oe_cyc  = 0;
    logic [7:0] last_wa = 8'd0;
    logic [7:0] last_wd = 8'd0;

    always @(posedge clk) begin
        if (wr_strobe) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= wr_addr;
            last_wd <= wr_data;
        end
        if (rd_strobe) rd_cnt <= rd_cnt + 1;
        if (sio_d_oe)  oe_cyc <= oe_cyc + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SIOC period starting and ending with SIOC low; returns the line
    // value sampled in the middle of the high phase.
    task automatic send_bit(input logic b, output logic line);
        m_d = b;
        wait_clk(4);
        sio_c = 1'b1;
        wait_clk(4);
        line = sio_d_in;
        wait_clk(4);
        sio_c = 1'b0;
        wait_clk(4);
    endtask

    task automatic start_cond();
        m_d = 1'b1;
        wait_clk(4);
        sio_c = 1'b1;
        wait_clk(4);
        m_d = 1'b0;
        wait_clk(4);
        sio_c = 1'b0;
        wait_clk(4);
    endtask

    task automatic stop_cond();
        m_d = 1'b0;
        wait_clk(4);
        sio_c = 1'b1;
        wait_clk(4);
        m_d = 1'b1;
        wait_clk(6);
    endtask

    // 8 data bits then a released 9th bit; ack = slave pulled the line low.
    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) send_bit(b[i], l);
        send_bit(1'b1, l);
        ack = ~l;
    endtask

    task automatic wb_chk(input logic [7:0] b, input logic exp_ack, input string tag);
        logic ack;
        write_byte(b, ack);
        check(tag, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na_line);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, l);
            b[i] = l;
        end
        send_bit(1'b1, l);
        na_line = l;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d, input string tag);
        start_cond();
        wb_chk(8'h42, 1'b1, {tag, "_ack_id"});
        wb_chk(a,     1'b1, {tag, "_ack_addr"});
        wb_chk(d,     1'b1, {tag, "_ack_data"});
        stop_cond();
    endtask

    task automatic set_ptr(input logic [7:0] a, input string tag);
        start_cond();
        wb_chk(8'h42, 1'b1, {tag, "_ack_id"});
        wb_chk(a,     1'b1, {tag, "_ack_addr"});
        stop_cond();
    endtask

    task automatic reg_read_chk(input logic [7:0] exp, input string tag);
        logic [7:0] d;
        logic       na;
        start_cond();
        wb_chk(8'h43, 1'b1, {tag, "_ack_id"});
        read_byte(d, na);
        check({tag, "_data"}, {24'd0, d}, {24'd0, exp});
        check({tag, "_na_released"}, {31'd0, na}, 32'd1);
        stop_cond();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         w0, r0, o0;
        logic [7:0] d;
        logic       na;
        logic       b_unused;

        // Reset values
        rst_n = 1'b0;
        wait_clk(3);
        check("rst_oe",        {31'd0, sio_d_oe},  32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_wr_addr",   {24'd0, wr_addr},   32'd0);
        check("rst_wr_data",   {24'd0, wr_data},   32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // T1: 3-phase write 0x42,0x22,0xFF
        w0 = wr_cnt;
        start_cond();
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        wb_chk(8'h42, 1'b1, "t1_ack_id");
        wb_chk(8'h22, 1'b1, "t1_ack_addr");
        wb_chk(8'hFF, 1'b1, "t1_ack_data");
        check("t1_busy_before_stop", {31'd0, busy}, 32'd1);
        stop_cond();
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("t1_wr_count", wr_cnt - w0, 32'd1);
        check("t1_wr_addr", {24'd0, last_wa}, 32'h22);
        check("t1_wr_data", {24'd0, last_wd}, 32'hFF);

        // T2: write 0x13=0xA5, set pointer to 0x13, read it back
        w0 = wr_cnt;
        reg_write(8'h13, 8'hA5, "t2_wr");
        check("t2_wr_count", wr_cnt - w0, 32'd1);
        check("t2_wr_addr", {24'd0, last_wa}, 32'h13);
        check("t2_wr_data", {24'd0, last_wd}, 32'hA5);
        set_ptr(8'h13, "t2_ptr");
        r0 = rd_cnt;
        reg_read_chk(8'hA5, "t2_rd");
        check("t2_rd_count", rd_cnt - r0, 32'd1);

        // T3: foreign ID 0x60 plus two bytes: ignored completely
        w0 = wr_cnt;
        r0 = rd_cnt;
        o0 = oe_cyc;
        start_cond();
        wb_chk(8'h60, 1'b0, "t3_ack_id");
        wb_chk(8'h11, 1'b0, "t3_ack_b1");
        wb_chk(8'h22, 1'b0, "t3_ack_b2");
        stop_cond();
        check("t3_oe_cycles", oe_cyc - o0, 32'd0);
        check("t3_wr_count", wr_cnt - w0, 32'd0);
        check("t3_rd_count", rd_cnt - r0, 32'd0);
        reg_read_chk(8'hA5, "t3_rd_unchanged");

        // T4: abort the data byte after 4 bits
        reg_write(8'h33, 8'h5C, "t4_pre33");
        reg_write(8'h34, 8'h77, "t4_pre34");
        w0 = wr_cnt;
        start_cond();
        wb_chk(8'h42, 1'b1, "t4_ack_id");
        wb_chk(8'h33, 1'b1, "t4_ack_addr");
        send_bit(1'b1, b_unused);
        send_bit(1'b0, b_unused);
        send_bit(1'b1, b_unused);
        send_bit(1'b0, b_unused);
        stop_cond();
        check("t4_wr_count", wr_cnt - w0, 32'd0);
        check("t4_busy_after_stop", {31'd0, busy}, 32'd0);
        reg_read_chk(8'h5C, "t4_rd_ptr33");

        // T6: repeated start after ADDR_ACK, then read
        reg_write(8'h55, 8'h3C, "t6_pre55");
        reg_write(8'h56, 8'h99, "t6_pre56");
        r0 = rd_cnt;
        start_cond();
        wb_chk(8'h42, 1'b1, "t6_ack_id");
        wb_chk(8'h55, 1'b1, "t6_ack_addr");
        start_cond();
        check("t6_busy_rs", {31'd0, busy}, 32'd1);
        wb_chk(8'h43, 1'b1, "t6_ack_rid");
        read_byte(d, na);
        check("t6_data", {24'd0, d}, 32'h3C);
        check("t6_na_released", {31'd0, na}, 32'd1);
        stop_cond();
        check("t6_rd_count", rd_cnt - r0, 32'd1);

        // T5: reset while the slave drives a 0 read bit
        reg_write(8'h40, 8'h0F, "t5_pre40");
        start_cond();
        wb_chk(8'h43, 1'b1, "t5_ack_rid");
        check("t5_driving_bit7", {31'd0, sio_d_oe}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_release", {31'd0, sio_d_oe}, 32'd0);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        sio_c = 1'b1;
        m_d   = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        reg_read_chk(8'h00, "t5_rd_ptr0");
        set_ptr(8'h40, "t5_ptr40");
        reg_read_chk(8'h00, "t5_rd_40");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
